fsfifo_wr_arb: RTL
==================

FSFIFO_WR_ARB -- requirements
Module: fsfifo_wr_arb

Interface
- Parameters
  - REQ-001: WIDTH, default 32, word width of each requester and of the FIFO write port.
  - REQ-002: NREQ, default 4, number of requesters (2..8).
  - REQ-003: BURST, default 4, maximum words one requester may transfer per grant (1..16).
- Ports
  - REQ-004: clk_i  input  1  single clock; all state changes on its rising edge.
  - REQ-005: reset_ni  input  1  asynchronous, active-low reset.
  - REQ-006: req_valid_i  input  NREQ  per-requester word valid; bit k belongs to requester k.
  - REQ-007: req_data_i  input  NREQ*WIDTH  per-requester word; requester k owns bits [k*WIDTH +: WIDTH].
  - REQ-008: req_ready_o  output  NREQ  per-requester accept; a word transfers when valid and ready are both high at a clock edge.
  - REQ-009: fifo_full_i  input  1  full flag from the shared fsfifo.
  - REQ-010: fifo_wr_o  output  1  write strobe to the fsfifo.
  - REQ-011: fifo_wr_data_o  output  WIDTH  write data to the fsfifo.
  - REQ-012: grant_o  output  NREQ  one-hot current owner; all zero when idle.
  - REQ-013: busy_o  output  1  high while in state OWN.
  - REQ-014: xfer_cnt_o  output  16  total words written since reset, saturating at 16'hFFFF.

Function
- REQ-015: The FSM SHALL have exactly two states, IDLE and OWN.
- REQ-016: In IDLE, if any req_valid_i bit is high, the block SHALL select the first valid requester at or after rr_ptr, searching upward with wrap-around modulo NREQ.
- REQ-017: On that selection the block SHALL load the owner, clear burst_cnt, and enter OWN at the next edge (one cycle of arbitration latency, during which req_ready_o is all zero).
- REQ-018: In IDLE with no valid request, the FSM SHALL remain in IDLE and rr_ptr SHALL be unchanged.
- REQ-019: In OWN, req_ready_o[owner] SHALL equal !fifo_full_i (combinational), and every other req_ready_o bit SHALL be 0.
- REQ-020: fifo_wr_o SHALL equal req_valid_i[owner] && req_ready_o[owner] in OWN and SHALL be 0 in IDLE.
- REQ-021: fifo_wr_data_o SHALL pass req_data_i of the owner combinationally, and SHALL be 0 in IDLE.
- REQ-022: Each transfer in OWN SHALL increment burst_cnt by 1.
- REQ-023: OWN SHALL release (next state IDLE, rr_ptr <= (owner+1) mod NREQ) when either:
  - a transfer occurs with burst_cnt == BURST-1, or
  - req_valid_i[owner] is low in a cycle.
- REQ-024: While fifo_full_i is high and the owner is valid, the block SHALL hold ownership, leave burst_cnt unchanged, and not release; a full FIFO never forfeits a grant.
- REQ-025: Requester valid inputs other than the owner's SHALL have no effect in OWN.
- REQ-026: xfer_cnt_o SHALL increment by 1 on every fifo_wr_o cycle and hold at 16'hFFFF once reached.
- REQ-027: grant_o SHALL be the one-hot decode of owner in OWN.
- REQ-028: With BURST=1, every transfer SHALL release the grant.
- REQ-029: Sustained throughput for a single continuously valid requester SHALL be BURST words per BURST+1 cycles.

Reset
- REQ-030: Assertion of reset_ni low SHALL immediately, without a clock edge, force state=IDLE, owner=0, rr_ptr=0, burst_cnt=0 and xfer_cnt_o=0.
- REQ-031: During reset, grant_o, req_ready_o, fifo_wr_o, fifo_wr_data_o and busy_o SHALL all be 0.
- REQ-032: Reset asserted mid-burst SHALL abort the burst with no further fifo_wr_o; no partial state survives.
- REQ-033: After deassertion, the first arbitration SHALL begin searching at requester 0.

Verification
- REQ-034: NREQ=4, BURST=4; only req 2 valid continuously, FIFO never full. Required: grant_o=4'b0100, 4 writes in cycles 2-5, IDLE bubble, repeat; xfer_cnt_o=8 after 10 cycles.
- REQ-035: All 4 valid continuously. Required: grant order 0,1,2,3,0, each burst 4 words, fifo_wr_data_o sourced from the granted requester only.
- REQ-036: Owner 1 after 2 words; fifo_full_i high for 3 cycles. Required: req_ready_o=0 and fifo_wr_o=0 for those cycles, grant held, then 2 more words, then release.
- REQ-037: Owner 3 drops valid after 1 word. Required: release next edge, rr_ptr=0, the next grant goes to req 0 if valid.
- REQ-038: reset_ni pulsed low mid-burst (owner 2, burst_cnt=2). Required: outputs 0 immediately, xfer_cnt_o=0, the next grant searches from requester 0.
- REQ-039: Force 65540 writes. Required: xfer_cnt_o saturates at 16'hFFFF.

Source files
------------

// File: rtl/fsfifo_wr_arb.sv
// Round-robin write arbiter in front of a shared fsfifo.
// A requester holds the grant for up to BURST words.
module fsfifo_wr_arb #(
  parameter int WIDTH = 32,
  parameter int NREQ  = 4,
  parameter int BURST = 4
) (
  input  logic                  clk_i,
  input  logic                  reset_ni,
  input  logic [NREQ-1:0]       req_valid_i,
  input  logic [NREQ*WIDTH-1:0] req_data_i,
  output logic [NREQ-1:0]       req_ready_o,
  input  logic                  fifo_full_i,
  output logic                  fifo_wr_o,
  output logic [WIDTH-1:0]      fifo_wr_data_o,
  output logic [NREQ-1:0]       grant_o,
  output logic                  busy_o,
  output logic [15:0]           xfer_cnt_o
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int BW = (BURST > 1) ? $clog2(BURST) : 1;
  localparam logic [BW-1:0] BLAST = BW'(BURST - 1);
  localparam logic [IW:0] NMOD = (IW + 1)'(NREQ);
  localparam logic [IW-1:0] LASTR = IW'(NREQ - 1);

  typedef enum logic {
    IDLE = 1'b0,
    OWN  = 1'b1
  } state_t;

  state_t          r_state;
  logic [IW-1:0]   r_owner;
  logic [IW-1:0]   r_rr_ptr;
  logic [BW-1:0]   r_burst_cnt;
  logic [15:0]     r_xfer_cnt;

  logic [WIDTH-1:0]  w_data [NREQ];
  logic [2*NREQ-1:0] w_dbl;
  logic [NREQ-1:0]   w_rot;
  logic [IW-1:0]     w_off;
  logic [IW:0]       w_sum;
  logic [IW-1:0]     w_sel;
  logic [IW-1:0]     w_next_rr;
  logic              w_own;
  logic              w_own_valid;
  logic              w_xfer;
  logic              w_last;

  for (genvar k = 0; k < NREQ; k++) begin : g_unpack
    assign w_data[k] = req_data_i[k*WIDTH +: WIDTH];
  end

  // Rotate valids so bit 0 is the requester at rr_ptr.
  assign w_dbl = {req_valid_i, req_valid_i};
  assign w_rot = w_dbl[r_rr_ptr +: NREQ];

  // Lowest set offset in the rotated vector wins.
  always_comb begin
    w_off = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (w_rot[i]) w_off = IW'(i);
    end
  end

  assign w_sum = {1'b0, r_rr_ptr} + {1'b0, w_off};
  assign w_sel = (w_sum >= NMOD) ? IW'(w_sum - NMOD)
                                 : w_sum[IW-1:0];

  assign w_next_rr = (r_owner == LASTR) ? '0
                                        : r_owner + IW'(1);

  assign w_own       = (r_state == OWN);
  assign w_own_valid = req_valid_i[r_owner];
  assign w_xfer      = w_own && w_own_valid && !fifo_full_i;
  assign w_last      = (r_burst_cnt == BLAST);

  // Only the owner sees ready, and only while the FIFO has room.
  always_comb begin
    req_ready_o = '0;
    if (w_own) req_ready_o[r_owner] = !fifo_full_i;
  end

  assign fifo_wr_o      = w_xfer;
  assign fifo_wr_data_o = w_own ? w_data[r_owner] : '0;
  assign grant_o        = w_own ? (NREQ'(1) << r_owner) : '0;
  assign busy_o         = w_own;
  assign xfer_cnt_o     = r_xfer_cnt;

  // Arbitration FSM, burst tracking and saturating word counter.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      r_state     <= IDLE;
      r_owner     <= '0;
      r_rr_ptr    <= '0;
      r_burst_cnt <= '0;
      r_xfer_cnt  <= '0;
    end else begin
      if (w_xfer && (r_xfer_cnt != 16'hFFFF)) begin
        r_xfer_cnt <= r_xfer_cnt + 16'd1;
      end
      unique case (r_state)
        IDLE: begin
          if (|req_valid_i) begin
            r_owner     <= w_sel;
            r_burst_cnt <= '0;
            r_state     <= OWN;
          end
        end
        OWN: begin
          if (!w_own_valid) begin
            r_state  <= IDLE;
            r_rr_ptr <= w_next_rr;
          end else if (w_xfer) begin
            if (w_last) begin
              r_state  <= IDLE;
              r_rr_ptr <= w_next_rr;
            end else begin
              r_burst_cnt <= r_burst_cnt + BW'(1);
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule
